// File: rtl/melody_sequencer_if.sv
// Control, table-write and buzzer-status bundle for melody_sequencer.
// The master side drives control and table writes; the slave side is the sequencer.
interface melody_sequencer_if #(
    parameter int DUR_W = 4
);
    logic             input_start;
    logic             input_stop;
    logic             input_loop;
    logic [2:0]       input_length;
    logic             input_wr_en;
    logic [2:0]       input_wr_addr;
    logic [2:0]       input_wr_note;
    logic             input_wr_rest;
    logic [DUR_W-1:0] input_wr_dur;
    logic [7:0]       output_buzzer;
    logic             output_busy;
    logic             output_done;
    logic [2:0]       output_step;

    modport master (
        output input_start,
        output input_stop,
        output input_loop,
        output input_length,
        output input_wr_en,
        output input_wr_addr,
        output input_wr_note,
        output input_wr_rest,
        output input_wr_dur,
        input  output_buzzer,
        input  output_busy,
        input  output_done,
        input  output_step
    );

    modport slave (
        input  input_start,
        input  input_stop,
        input  input_loop,
        input  input_length,
        input  input_wr_en,
        input  input_wr_addr,
        input  input_wr_note,
        input  input_wr_rest,
        input  input_wr_dur,
        output output_buzzer,
        output output_busy,
        output output_done,
        output output_step
    );
endinterface

// File: rtl/melody_sequencer.sv
// Step sequencer for the 8-buzzer note bank: plays a small note table with
// per-step duration, inter-note gap, rests, loop mode and start/stop control.
module melody_sequencer #(
    parameter int STEPS     = 8,
    parameter int TICK_DIV  = 4,
    parameter int DUR_W     = 4,
    parameter int GAP_TICKS = 1
) (
    input  logic              input_clock1_1,
    input  logic              input_reset_n,
    melody_sequencer_if.slave bus
);

    localparam int CYC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_W = $clog2(GAP_TICKS + 1);
    localparam int TCK_W = ((DUR_W > GAP_W) ? DUR_W : GAP_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_GAP
    } state_t;

    state_t           r_state;
    state_t           w_nstate;
    logic [CYC_W-1:0] r_cyc;
    logic [TCK_W-1:0] r_tick;
    logic [2:0]       r_step;
    logic [2:0]       r_len;
    logic [2:0]       r_note;
    logic             r_rest;
    logic [DUR_W-1:0] r_dur;

    logic [2:0]       r_tab_note [STEPS];
    logic             r_tab_rest [STEPS];
    logic [DUR_W-1:0] r_tab_dur  [STEPS];

    logic [7:0]       r_buzzer;
    logic             r_busy;
    logic             r_done;
    logic [2:0]       r_ostep;

    logic [2:0]       w_nstep;
    logic             w_fetch;
    logic             w_done;
    logic             w_tick_end;
    logic             w_play_end;
    logic             w_gap_end;
    logic             w_last;
    logic             w_restart;
    logic [2:0]       w_cur_note;
    logic             w_cur_rest;
    logic [7:0]       w_buzzer;

    always_comb begin
        w_tick_end = (r_cyc == CYC_W'(TICK_DIV - 1));
        w_play_end = w_tick_end && (r_tick == TCK_W'(r_dur));
        w_gap_end  = w_tick_end && (r_tick == TCK_W'(GAP_TICKS - 1));
        w_last     = (r_step == r_len);
    end

    always_comb begin
        w_nstate = r_state;
        w_nstep  = r_step;
        w_fetch  = 1'b0;
        w_done   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.input_start && !bus.input_stop) begin
                    w_nstate = S_PLAY;
                    w_nstep  = 3'd0;
                    w_fetch  = 1'b1;
                end
            end
            S_PLAY: begin
                if (bus.input_stop) begin
                    w_nstate = S_IDLE;
                    w_nstep  = 3'd0;
                end else if (w_play_end) begin
                    if (w_last && !bus.input_loop) begin
                        w_nstate = S_IDLE;
                        w_nstep  = 3'd0;
                        w_done   = 1'b1;
                    end else if (GAP_TICKS > 0) begin
                        w_nstate = S_GAP;
                    end else begin
                        w_nstate = S_PLAY;
                        w_fetch  = 1'b1;
                        w_nstep  = w_last ? 3'd0 : r_step + 3'd1;
                    end
                end
            end
            S_GAP: begin
                if (bus.input_stop) begin
                    w_nstate = S_IDLE;
                    w_nstep  = 3'd0;
                end else if (w_gap_end) begin
                    // Reaching a gap after the last step implies loop mode.
                    w_nstate = S_PLAY;
                    w_fetch  = 1'b1;
                    w_nstep  = w_last ? 3'd0 : r_step + 3'd1;
                end
            end
            default: begin
                w_nstate = S_IDLE;
                w_nstep  = 3'd0;
            end
        endcase
    end

    always_comb begin
        w_restart  = (w_nstate != r_state) || w_fetch;
        w_cur_note = w_fetch ? r_tab_note[w_nstep] : r_note;
        w_cur_rest = w_fetch ? r_tab_rest[w_nstep] : r_rest;
        w_buzzer   = 8'h00;
        if (w_nstate == S_PLAY && !w_cur_rest) begin
            w_buzzer = 8'b1 << w_cur_note;
        end
    end

    always_ff @(posedge input_clock1_1 or negedge input_reset_n) begin
        if (!input_reset_n) begin
            r_state  <= S_IDLE;
            r_cyc    <= '0;
            r_tick   <= '0;
            r_step   <= 3'd0;
            r_len    <= 3'd0;
            r_note   <= 3'd0;
            r_rest   <= 1'b0;
            r_dur    <= '0;
            r_buzzer <= 8'h00;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ostep  <= 3'd0;
            for (int i = 0; i < STEPS; i++) begin
                r_tab_note[i] <= 3'd0;
                r_tab_rest[i] <= 1'b0;
                r_tab_dur[i]  <= '0;
            end
        end else begin
            r_state <= w_nstate;
            r_step  <= w_nstep;
            if (w_restart || w_nstate == S_IDLE) begin
                r_cyc  <= '0;
                r_tick <= '0;
            end else if (w_tick_end) begin
                r_cyc  <= '0;
                r_tick <= r_tick + TCK_W'(1);
            end else begin
                r_cyc <= r_cyc + CYC_W'(1);
            end
            if (r_state == S_IDLE && w_fetch) begin
                r_len <= bus.input_length;
            end
            if (w_fetch) begin
                r_note <= r_tab_note[w_nstep];
                r_rest <= r_tab_rest[w_nstep];
                r_dur  <= r_tab_dur[w_nstep];
            end
            r_buzzer <= w_buzzer;
            r_busy   <= (w_nstate != S_IDLE);
            r_done   <= w_done;
            r_ostep  <= w_nstep;
            if (bus.input_wr_en) begin
                r_tab_note[bus.input_wr_addr] <= bus.input_wr_note;
                r_tab_rest[bus.input_wr_addr] <= bus.input_wr_rest;
                r_tab_dur[bus.input_wr_addr]  <= bus.input_wr_dur;
            end
        end
    end

    assign bus.output_buzzer = r_buzzer;
    assign bus.output_busy   = r_busy;
    assign bus.output_done   = r_done;
    assign bus.output_step   = r_ostep;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: directed scenarios plus random control traffic,
// every output compared each cycle against a phase/remaining-cycles model.
module tb_melody_sequencer;

    localparam int TD = 4;
    localparam int GT = 1;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    melody_sequencer_if #(.DUR_W(DW)) bus ();

    melody_sequencer #(
        .STEPS(8),
        .TICK_DIV(TD),
        .DUR_W(DW),
        .GAP_TICKS(GT)
    ) dut (
        .input_clock1_1(clk),
        .input_reset_n(rst_n),
        .bus(bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model: phase 0 idle, 1 play, 2 gap; m_left = cycles left in phase.
    int         m_ph, m_left, m_step, m_len, m_next;
    logic [7:0] m_buz;
    logic       m_done;
    int         t_note [8];
    int         t_rest [8];
    int         t_dur  [8];

    logic [7:0] seg_buz  [5] = '{8'h20, 8'h00, 8'h04, 8'h00, 8'h80};
    int         seg_len  [5] = '{8, 4, 4, 4, 12};
    int         seg_step [5] = '{0, 0, 1, 1, 2};

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        m_ph = 0; m_left = 0; m_step = 0; m_len = 0; m_next = 0;
        m_buz = 8'h00; m_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            t_note[i] = 0; t_rest[i] = 0; t_dur[i] = 0;
        end
    endfunction

    function automatic void m_play(int s);
        m_ph   = 1;
        m_step = s;
        m_left = (t_dur[s] + 1) * TD;
        m_buz  = (t_rest[s] != 0) ? 8'h00 : 8'(1 << t_note[s]);
    endfunction

    function automatic void m_edge();
        m_done = 1'b0;
        if (m_ph == 0) begin
            if (bus.input_start && !bus.input_stop) begin
                m_len = int'(bus.input_length);
                m_play(0);
            end
        end else if (bus.input_stop) begin
            m_ph = 0; m_step = 0; m_buz = 8'h00;
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                if (m_ph == 2) begin
                    m_play(m_next);
                end else if (m_step == m_len && !bus.input_loop) begin
                    m_ph = 0; m_step = 0; m_buz = 8'h00; m_done = 1'b1;
                end else begin
                    m_next = (m_step == m_len) ? 0 : (m_step + 1) % 8;
                    if (GT > 0) begin
                        m_ph = 2; m_left = GT * TD; m_buz = 8'h00;
                    end else begin
                        m_play(m_next);
                    end
                end
            end
        end
        if (bus.input_wr_en) begin
            t_note[bus.input_wr_addr] = int'(bus.input_wr_note);
            t_rest[bus.input_wr_addr] = int'(bus.input_wr_rest);
            t_dur[bus.input_wr_addr]  = int'(bus.input_wr_dur);
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        if (!rst_n) m_reset();
        else m_edge();
        #1;
        check("buzzer", bus.output_buzzer, m_buz);
        check("busy", bus.output_busy, (m_ph != 0));
        check("done", bus.output_done, m_done);
        check("step", bus.output_step, m_step);
    endtask

    task automatic clr();
        bus.input_start = 0; bus.input_stop = 0; bus.input_loop = 0;
        bus.input_length = 0; bus.input_wr_en = 0; bus.input_wr_addr = 0;
        bus.input_wr_note = 0; bus.input_wr_rest = 0; bus.input_wr_dur = 0;
    endtask

    task automatic wr(int a, int n, int r, int d);
        bus.input_wr_en   = 1;
        bus.input_wr_addr = 3'(a);
        bus.input_wr_note = 3'(n);
        bus.input_wr_rest = 1'(r);
        bus.input_wr_dur  = DW'(d);
        cyc();
        bus.input_wr_en = 0;
    endtask

    task automatic wait_play(string tag, int st, int lim);
        int n = 0;
        while (!(m_ph == 1 && m_step == st) && n < lim) begin
            cyc();
            n++;
        end
        check(tag, {bus.output_busy, bus.output_step}, {1'b1, 3'(st)});
    endtask

    task automatic wait_done(string tag, int lim);
        int n = 0;
        while (!bus.output_done && n < lim) begin
            cyc();
            n++;
        end
        check(tag, bus.output_done, 1);
    endtask

    initial begin
        int bc;
        int dn;
        clr();
        m_reset();
        #12;
        check("rst_buzzer", bus.output_buzzer, 8'h00);
        check("rst_busy", bus.output_busy, 0);
        check("rst_step", bus.output_step, 0);
        rst_n = 1'b1;
        cyc();

        // Basic play with exact per-phase expectations
        wr(0, 5, 0, 1);
        wr(1, 2, 0, 0);
        wr(2, 7, 0, 2);
        bus.input_length = 3'd2;
        bus.input_start  = 1;
        cyc();
        bus.input_start = 0;
        for (int s = 0; s < 5; s++) begin
            for (int k = 0; k < seg_len[s]; k++) begin
                check("t2_buz", bus.output_buzzer, seg_buz[s]);
                check("t2_step", bus.output_step, seg_step[s]);
                cyc();
            end
        end
        check("t2_done", bus.output_done, 1);
        check("t2_idle", bus.output_busy, 0);
        cyc();
        check("t2_done_once", bus.output_done, 0);

        // Asynchronous reset mid-play, then held with start high
        bus.input_start = 1;
        cyc();
        bus.input_start = 0;
        repeat (5) cyc();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_buzzer", bus.output_buzzer, 8'h00);
        check("arst_busy", bus.output_busy, 0);
        check("arst_done", bus.output_done, 0);
        check("arst_step", bus.output_step, 0);
        m_reset();
        bus.input_start = 1;
        repeat (3) cyc();
        bus.input_start = 0;
        rst_n = 1'b1;
        cyc();

        // Rest with maximum duration
        wr(0, 4, 1, 15);
        bus.input_length = 3'd0;
        bus.input_start  = 1;
        cyc();
        bus.input_start = 0;
        bc = 0;
        for (int i = 0; i < 80; i++) begin
            if (bus.output_busy) bc++;
            if (bus.output_done) break;
            cyc();
        end
        check("t3_busy_cycles", bc, 64);
        check("t3_done", bus.output_done, 1);

        // Loop; entry 1 still holds its cleared value
        wr(0, 3, 0, 2);
        bus.input_length = 3'd1;
        bus.input_loop   = 1;
        bus.input_start  = 1;
        cyc();
        bus.input_start = 0;
        dn = 0;
        repeat (60) begin
            cyc();
            dn += int'(bus.output_done);
        end
        check("t4_no_done", dn, 0);
        wait_play("t4_step1", 1, 40);
        check("t4_cleared_entry", bus.output_buzzer, 8'h01);
        bus.input_loop = 0;
        wait_done("t4_done", 40);
        cyc();

        // Stop mid-step, start+stop in idle, start while busy
        bus.input_loop  = 1;
        bus.input_start = 1;
        cyc();
        bus.input_start = 0;
        wait_play("t5_step1", 1, 40);
        bus.input_stop = 1;
        cyc();
        bus.input_stop = 0;
        check("t5_stop_busy", bus.output_busy, 0);
        check("t5_stop_buz", bus.output_buzzer, 8'h00);
        check("t5_stop_nodone", bus.output_done, 0);
        bus.input_start = 1;
        bus.input_stop  = 1;
        cyc();
        bus.input_stop = 0;
        bus.input_start = 0;
        check("t5_conflict", bus.output_busy, 0);
        bus.input_start = 1;
        cyc();
        repeat (6) cyc();
        bus.input_start = 0;
        repeat (20) cyc();

        // Live write to the sounding step
        wait_play("t6_step0", 0, 40);
        wr(0, 6, 0, 2);
        check("t6_unchanged", bus.output_buzzer, 8'h08);
        wait_play("t6_step1", 1, 40);
        wait_play("t6_next_pass", 0, 40);
        check("t6_new_note", bus.output_buzzer, 8'h40);
        bus.input_stop = 1;
        cyc();
        clr();
        cyc();

        // Random control and table traffic
        for (int i = 0; i < 3000; i++) begin
            bus.input_start = ($urandom_range(0, 9) == 0);
            bus.input_stop  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 29) == 0) bus.input_loop = ~bus.input_loop;
            if ($urandom_range(0, 19) == 0) bus.input_length = 3'($urandom);
            bus.input_wr_en   = ($urandom_range(0, 3) == 0);
            bus.input_wr_addr = 3'($urandom);
            bus.input_wr_note = 3'($urandom);
            bus.input_wr_rest = ($urandom_range(0, 4) == 0);
            bus.input_wr_dur  = DW'($urandom);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
